sdram_port_arb: RTL and testbench

Two-requester arbiter in front of sdram_ctrl.
- Port A: host/config writer-reader. Port B: waveform playback engine.
- Shares the single wren/rd command interface of sdram_ctrl.
- Routes returned read data (rdata/rdv) back to the issuing port using an in-order read tag queue.
- Bounds outstanding traffic so sdram_ctrl's 8-deep command buffers never overflow.

---
 rtl/sdram_arb_pkg.sv | 25 ++
 rtl/sdram_port_arb_tagq.sv | 56 +++++
 rtl/sdram_port_arb.sv | 183 ++++++++++++++++++
 tb/tb_sdram_port_arb.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sdram_arb_pkg : shared constants and types for sdram_port_arb       |
// | Revision      : 1.0                                                 |
// +--------------------------------------------------------------------+
package sdram_arb_pkg;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Depth of each sdram_ctrl command buffer; outstanding traffic must never exceed it.
    localparam int SDRAM_BUF_DEPTH = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        SERVE_A  = 2'd1,
        SERVE_B  = 2'd2
    } arb_state_t;

    function automatic int clamp_to_buf(input int v);
        return (v < SDRAM_BUF_DEPTH) ? v : SDRAM_BUF_DEPTH;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_port_arb_tagq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sdram_port_arb_tagq : in-order read tag FIFO (1 bit wide, port id)  |
// | Revision            : 1.0                                           |
// +--------------------------------------------------------------------+
module sdram_port_arb_tagq
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic [DEPTH-1:0]    r_mem;
    logic                w_pop_ok;
    logic                w_push_ok;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                   (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
    assign head  = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

    // A pop in the same cycle frees the slot a full-queue push needs.
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= push_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_port_arb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sdram_port_arb : two-port arbiter in front of sdram_ctrl            |
// | Option macro   : SDRAM_ARB_B_PRIO_EN (port B strict priority)       |
// | Revision       : 1.0                                                |
// +--------------------------------------------------------------------+
module sdram_port_arb
    import sdram_arb_pkg::*;
#(
    parameter int P_DATA_NBIT   = 16,
    parameter int P_ADDR_NBIT   = 16,
    parameter int P_BURST_MAX   = 4,
    parameter int P_MAX_WR      = 6,
    parameter int P_MAX_RD_LOG2 = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   a_req,
    input  logic                   a_we,
    input  logic [P_ADDR_NBIT-1:0] a_addr,
    input  logic [P_DATA_NBIT-1:0] a_wdata,
    output logic                   a_gnt,
    output logic [P_DATA_NBIT-1:0] a_rdata,
    output logic                   a_rdv,
    input  logic                   b_req,
    input  logic                   b_we,
    input  logic [P_ADDR_NBIT-1:0] b_addr,
    input  logic [P_DATA_NBIT-1:0] b_wdata,
    output logic                   b_gnt,
    output logic [P_DATA_NBIT-1:0] b_rdata,
    output logic                   b_rdv,
    output logic                   m_wren,
    output logic [P_ADDR_NBIT-1:0] m_waddr,
    output logic [P_DATA_NBIT-1:0] m_wdata,
    output logic                   m_rd,
    output logic [P_ADDR_NBIT-1:0] m_raddr,
    input  logic [P_DATA_NBIT-1:0] m_rdata,
    input  logic                   m_rdv,
    input  logic                   m_wstatus,
    output logic                   busy
);

    localparam int WR_LIMIT  = clamp_to_buf(P_MAX_WR);
    localparam int TAGQ_LOG2 = ((1 << P_MAX_RD_LOG2) > SDRAM_BUF_DEPTH) ?
                               $clog2(SDRAM_BUF_DEPTH) : P_MAX_RD_LOG2;
    localparam int WW        = $clog2(WR_LIMIT + 1);
    localparam int BW        = $clog2(P_BURST_MAX + 1);
    localparam logic [WW-1:0] WR_LIMIT_C  = WW'(WR_LIMIT);
    localparam logic [WW-1:0] WR_ONE      = 1;
    localparam logic [BW-1:0] BURST_MAX_C = BW'(P_BURST_MAX);
    localparam logic [BW-1:0] BURST_ONE   = 1;

    arb_state_t      r_state, w_state_nxt;
    logic [BW-1:0]   r_burst, w_burst_nxt;
    logic            r_last, w_last_nxt;
    logic [WW-1:0]   r_wr_cnt;
    logic            r_wr_gnt_d;
    logic            w_tag_head, w_tag_full, w_tag_empty, w_tag_room;
    logic            w_elig_a, w_elig_b, w_gnt_a, w_gnt_b;
    logic            w_gnt_wr, w_gnt_rd;
    logic [P_ADDR_NBIT-1:0] w_sel_addr;
    logic [P_DATA_NBIT-1:0] w_sel_wdata;

    assign w_tag_room = !w_tag_full || m_rdv;
    assign w_elig_a   = a_req && (a_we ? (r_wr_cnt < WR_LIMIT_C) : w_tag_room);
    assign w_elig_b   = b_req && (b_we ? (r_wr_cnt < WR_LIMIT_C) : w_tag_room);

    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
`ifdef SDRAM_ARB_B_PRIO_EN
        if (w_elig_b)      w_gnt_b = 1'b1;
        else if (w_elig_a) w_gnt_a = 1'b1;
`else
        case (r_state)
            SERVE_A: begin
                // The burst limit only bites while B is actually able to take over.
                if (w_elig_a && (r_burst < BURST_MAX_C || !w_elig_b)) w_gnt_a = 1'b1;
                else if (w_elig_b)                                    w_gnt_b = 1'b1;
            end
            SERVE_B: begin
                if (w_elig_b && (r_burst < BURST_MAX_C || !w_elig_a)) w_gnt_b = 1'b1;
                else if (w_elig_a)                                    w_gnt_a = 1'b1;
            end
            default: begin
                if (w_elig_a && w_elig_b) begin
                    w_gnt_a = (r_last == PORT_B);
                    w_gnt_b = (r_last == PORT_A);
                end else begin
                    w_gnt_a = w_elig_a;
                    w_gnt_b = w_elig_b;
                end
            end
        endcase
`endif
    end

    always_comb begin
        w_state_nxt = ARB_IDLE;
        w_burst_nxt = '0;
        w_last_nxt  = r_last;
        if (w_gnt_a) begin
            w_state_nxt = SERVE_A;
            w_last_nxt  = PORT_A;
            w_burst_nxt = (r_state != SERVE_A) ? BURST_ONE :
                          (r_burst < BURST_MAX_C) ? r_burst + BURST_ONE : r_burst;
        end else if (w_gnt_b) begin
            w_state_nxt = SERVE_B;
            w_last_nxt  = PORT_B;
            w_burst_nxt = (r_state != SERVE_B) ? BURST_ONE :
                          (r_burst < BURST_MAX_C) ? r_burst + BURST_ONE : r_burst;
        end
    end

    assign a_gnt       = w_gnt_a;
    assign b_gnt       = w_gnt_b;
    assign w_gnt_wr    = (w_gnt_a && a_we) || (w_gnt_b && b_we);
    assign w_gnt_rd    = (w_gnt_a && !a_we) || (w_gnt_b && !b_we);
    assign w_sel_addr  = w_gnt_b ? b_addr  : a_addr;
    assign w_sel_wdata = w_gnt_b ? b_wdata : a_wdata;
    assign busy        = (r_state != ARB_IDLE) || !w_tag_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ARB_IDLE;
            r_burst    <= '0;
            r_last     <= PORT_B;
            r_wr_cnt   <= '0;
            r_wr_gnt_d <= 1'b0;
            m_wren     <= 1'b0;
            m_waddr    <= '0;
            m_wdata    <= '0;
            m_rd       <= 1'b0;
            m_raddr    <= '0;
            a_rdv      <= 1'b0;
            a_rdata    <= '0;
            b_rdv      <= 1'b0;
            b_rdata    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_burst    <= w_burst_nxt;
            r_last     <= w_last_nxt;
            r_wr_gnt_d <= w_gnt_wr;
            m_wren     <= w_gnt_wr;
            m_rd       <= w_gnt_rd;
            if (w_gnt_wr) begin
                m_waddr <= w_sel_addr;
                m_wdata <= w_sel_wdata;
            end
            if (w_gnt_rd) m_raddr <= w_sel_addr;
            // Write buffer is only trusted empty once no write is still in flight to it.
            if (w_gnt_wr)                      r_wr_cnt <= r_wr_cnt + WR_ONE;
            else if (m_wstatus && !r_wr_gnt_d) r_wr_cnt <= '0;
            a_rdv <= m_rdv && !w_tag_empty && (w_tag_head == PORT_A);
            b_rdv <= m_rdv && !w_tag_empty && (w_tag_head == PORT_B);
            if (m_rdv && !w_tag_empty && (w_tag_head == PORT_A)) a_rdata <= m_rdata;
            if (m_rdv && !w_tag_empty && (w_tag_head == PORT_B)) b_rdata <= m_rdata;
        end
    end

`ifndef SYNTHESIS
    logic r_stray_rdv;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_stray_rdv <= 1'b0;
        else        r_stray_rdv <= r_stray_rdv | (m_rdv & w_tag_empty);
    end
`endif

    sdram_port_arb_tagq #(
        .DEPTH_LOG2 (TAGQ_LOG2)
    ) u_tagq (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (w_gnt_rd),
        .push_id (w_gnt_b),
        .pop     (m_rdv),
        .head    (w_tag_head),
        .full    (w_tag_full),
        .empty   (w_tag_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sdram_port_arb : directed self-checking bench for sdram_port_arb |
// | Revision          : 1.0                                             |
// +--------------------------------------------------------------------+
module tb_sdram_port_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_gnt, a_rdv, b_gnt, b_rdv;
    logic [15:0] a_rdata, b_rdata;
    logic        m_wren, m_rd, m_rdv, m_wstatus, busy;
    logic [15:0] m_waddr, m_wdata, m_raddr, m_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sdram_port_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .a_rdata   (a_rdata),
        .a_rdv     (a_rdv),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_gnt     (b_gnt),
        .b_rdata   (b_rdata),
        .b_rdv     (b_rdv),
        .m_wren    (m_wren),
        .m_waddr   (m_waddr),
        .m_wdata   (m_wdata),
        .m_rd      (m_rd),
        .m_raddr   (m_raddr),
        .m_rdata   (m_rdata),
        .m_rdv     (m_rdv),
        .m_wstatus (m_wstatus),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] out_vec();
        return {16'(0), a_gnt, b_gnt, a_rdv, b_rdv, m_wren, m_rd, busy,
                |a_rdata, |b_rdata, |m_waddr, |m_wdata, |m_raddr, 4'(0)};
    endfunction

    initial begin
        int a_sent, b_sent, a_rx, b_rx, granted, left;
        logic [1:0] exp_g;

        rst_n = 1'b0; a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        m_rdata = 0; m_rdv = 0; m_wstatus = 1'b1;
        tick();
        tick();
        check("reset_outputs", out_vec(), 32'h0);
        rst_n = 1'b1;
        tick();

        // Single-port write
        a_req = 1; a_we = 1; a_addr = 16'h0010; a_wdata = 16'hBEEF;
        #1;
        check("wr_a_gnt", 32'(a_gnt), 32'h1);
        check("wr_no_b_gnt", 32'(b_gnt), 32'h0);
        tick();
        a_req = 0;
        check("wr_m_wren", 32'({m_wren, m_rd}), 32'h2);
        check("wr_m_waddr", 32'(m_waddr), 32'h0010);
        check("wr_m_wdata", 32'(m_wdata), 32'hBEEF);
        tick();
        check("wr_pulse_1cyc", 32'(m_wren), 32'h0);
        tick();
        check("wr_idle_busy", 32'(busy), 32'h0);

        // Contention: 8 reads per port, responder returns one m_rdv per m_rd
        do_reset();
        a_sent = 0; b_sent = 0; a_rx = 0; b_rx = 0;
        a_we = 0; b_we = 0;
        for (int cyc = 0; cyc < 22; cyc++) begin
            if (a_rdv) begin
                check("cont_a_rdata", 32'(a_rdata), 32'((16'h0100 + 16'(a_rx)) ^ 16'h5A5A));
                a_rx++;
            end
            if (b_rdv) begin
                check("cont_b_rdata", 32'(b_rdata), 32'((16'h0200 + 16'(b_rx)) ^ 16'h5A5A));
                b_rx++;
            end
            m_rdv   = m_rd;
            m_rdata = m_raddr ^ 16'h5A5A;
            a_req   = (a_sent < 8);
            b_req   = (b_sent < 8);
            a_addr  = 16'h0100 + 16'(a_sent);
            b_addr  = 16'h0200 + 16'(b_sent);
            #1;
            if (cyc < 16) begin
                exp_g = (((cyc / 4) % 2) == 0) ? 2'b01 : 2'b10;
                check("cont_gnt_seq", 32'({b_gnt, a_gnt}), 32'(exp_g));
            end
            if (a_gnt) a_sent++;
            if (b_gnt) b_sent++;
            tick();
        end
        m_rdv = 0;
        check("cont_a_rx", 32'(a_rx), 32'd8);
        check("cont_b_rx", 32'(b_rx), 32'd8);
        check("cont_busy_done", 32'(busy), 32'h0);

        // Read routing
        a_req = 1; a_we = 0; a_addr = 16'h0100;
        #1;
        check("rt_a_gnt", 32'(a_gnt), 32'h1);
        tick();
        a_req = 0; b_req = 1; b_we = 0; b_addr = 16'h0200;
        check("rt_m_raddr_a", 32'({m_rd, m_raddr}), 32'h1_0100);
        #1;
        check("rt_b_gnt", 32'(b_gnt), 32'h1);
        tick();
        b_req = 0;
        check("rt_m_raddr_b", 32'({m_rd, m_raddr}), 32'h1_0200);
        m_rdv = 1; m_rdata = 16'h1111;
        tick();
        check("rt_a_rdv", 32'({a_rdv, b_rdv}), 32'h2);
        check("rt_a_rdata", 32'(a_rdata), 32'h1111);
        m_rdv = 1; m_rdata = 16'h2222;
        tick();
        m_rdv = 0;
        check("rt_b_rdv", 32'({a_rdv, b_rdv}), 32'h1);
        check("rt_b_rdata", 32'(b_rdata), 32'h2222);
        tick();
        check("rt_busy_done", 32'(busy), 32'h0);

        // Write throttle
        m_wstatus = 0; granted = 0; left = 10;
        a_we = 1; a_wdata = 16'h00AA;
        for (int i = 0; i < 12; i++) begin
            a_req = (left > 0);
            a_addr = 16'h0300 + 16'(granted);
            #1;
            if (a_gnt) begin granted++; left--; end
            tick();
        end
        check("thr_granted_6", 32'(granted), 32'd6);
        #1;
        check("thr_stalled", 32'(a_gnt), 32'h0);
        m_wstatus = 1;
        tick();
        for (int i = 0; i < 6; i++) begin
            a_req = (left > 0);
            a_addr = 16'h0300 + 16'(granted);
            #1;
            if (i == 0) check("thr_resume", 32'(a_gnt), 32'h1);
            if (a_gnt) begin granted++; left--; end
            tick();
            if (i == 0) m_wstatus = 0;
        end
        a_req = 0;
        check("thr_granted_10", 32'(granted), 32'd10);
        m_wstatus = 1;
        tick();
        tick();

        // Tag queue full
        a_req = 1; a_we = 0;
        for (int i = 0; i < 8; i++) begin
            a_addr = 16'h0400 + 16'(i);
            #1;
            check("tf_gnt_fill", 32'(a_gnt), 32'h1);
            tick();
        end
        a_addr = 16'h0408;
        #1;
        check("tf_9th_blocked", 32'(a_gnt), 32'h0);
        tick();
        check("tf_busy", 32'(busy), 32'h1);
        m_rdv = 1; m_rdata = 16'h7777;
        #1;
        check("tf_9th_with_pop", 32'(a_gnt), 32'h1);
        tick();
        a_req = 0; m_rdv = 0;
        check("tf_pop_rdv", 32'({a_rdv, m_rd}), 32'h3);

        // Asynchronous reset with 8 reads still outstanding
        #2;
        rst_n = 0;
        #1;
        check("rst_async_outputs", out_vec(), 32'h0);
        tick();
        rst_n = 1;
        tick();
        m_rdv = 1; m_rdata = 16'h9999;
        tick();
        m_rdv = 0;
        check("rst_stray_rdv", 32'({a_rdv, b_rdv}), 32'h0);
        tick();
        check("rst_stray_after", out_vec(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
